// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing constants and types for the register file
package regfile_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: combinational DEPTH:1 read mux over the register array
module regfile_read_port #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);
  assign data = regs[addr];
endmodule

// File: rtl/register_file_8x4.sv
// register_file_8x4: 16x8 register file, two combinational reads, one clocked write
module register_file_8x4 #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  input  logic [ADDR_W-1:0] Rw,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2
);
  logic [DATA_W-1:0] regs [2**ADDR_W];
  // reset clears every entry and wins over a same-cycle write
  always_ff @(posedge clk)
    if (rst)
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
    else if (wr)
      regs[Rw] <= Din;
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp1 (.regs(regs), .addr(R1), .data(OUT1));
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp2 (.regs(regs), .addr(R2), .data(OUT2));
endmodule

// File: tb/tb_register_file_8x4.sv
// tb_register_file_8x4: table-driven and hand-sequenced checks with a scoreboard queue
module tb_register_file_8x4;
  logic clk = 0, rst = 1, wr = 0;
  logic [3:0] R1 = 0, R2 = 0, Rw = 0;
  logic [7:0] Din = 0, OUT1, OUT2;
  int compared = 0, mismatched = 0;

  typedef struct {
    logic rst, wr;
    logic [3:0] rw, r1, r2;
    logic [7:0] din, e1, e2;
  } vec_t;

  typedef struct {
    string name;
    logic [7:0] e1, e2;
  } exp_t;

  vec_t vt [8];
  exp_t sbq [$];

  register_file_8x4 dut (
    .clk(clk), .rst(rst), .wr(wr), .R1(R1), .R2(R2), .Rw(Rw),
    .Din(Din), .OUT1(OUT1), .OUT2(OUT2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [3:0] a, input logic [3:0] p1,
                      input logic [3:0] p2, input logic [7:0] d, input logic [7:0] e1,
                      input logic [7:0] e2, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; wr = w; Rw = a; R1 = p1; R2 = p2; Din = d;
    sbq.push_back('{nm, e1, e2});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.name, ".out1"}, OUT1, e.e1);
    chk({e.name, ".out2"}, OUT2, e.e2);
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 4'd0,  4'd0, 4'd15, 8'h00, 8'h00, 8'h00};
    vt[1] = '{1'b0, 1'b1, 4'd0,  4'd0, 4'd1,  8'h02, 8'h02, 8'h00};
    vt[2] = '{1'b0, 1'b1, 4'd1,  4'd0, 4'd1,  8'h04, 8'h02, 8'h04};
    vt[3] = '{1'b0, 1'b1, 4'd2,  4'd2, 4'd3,  8'h06, 8'h06, 8'h00};
    vt[4] = '{1'b0, 1'b1, 4'd3,  4'd2, 4'd3,  8'h08, 8'h06, 8'h08};
    vt[5] = '{1'b0, 1'b0, 4'd0,  4'd0, 4'd1,  8'h00, 8'h02, 8'h04};
    vt[6] = '{1'b0, 1'b0, 4'd1,  4'd1, 4'd3,  8'hFF, 8'h04, 8'h08};
    vt[7] = '{1'b0, 1'b1, 4'd0,  4'd0, 4'd0,  8'h11, 8'h11, 8'h11};
    for (int i = 0; i < 8; i++)
      step(vt[i].rst, vt[i].wr, vt[i].rw, vt[i].r1, vt[i].r2, vt[i].din,
           vt[i].e1, vt[i].e2, $sformatf("vec%0d", i));
    @(negedge clk);
    wr = 0; R1 = 3; R2 = 2;
    #1;
    chk("comb_read.out1", OUT1, 8'h08);
    chk("comb_read.out2", OUT2, 8'h06);
    @(negedge clk);
    R1 = 5; R2 = 5; wr = 1; Rw = 5; Din = 8'hA5;
    #1;
    chk("rdw_pre.out1", OUT1, 8'h00);
    chk("rdw_pre.out2", OUT2, 8'h00);
    @(posedge clk);
    #1;
    chk("rdw_post.out1", OUT1, 8'hA5);
    chk("rdw_post.out2", OUT2, 8'hA5);
    step(1'b0, 1'b1, 4'd15, 4'd15, 4'd5, 8'h3C, 8'h3C, 8'hA5, "top_addr");
    step(1'b1, 1'b1, 4'd15, 4'd15, 4'd0, 8'h77, 8'h00, 8'h00, "rst_prio");
    step(1'b0, 1'b0, 4'd15, 4'd5,  4'd3, 8'h77, 8'h00, 8'h00, "post_rst");
    step(1'b0, 1'b1, 4'd15, 4'd15, 4'd0, 8'h5A, 8'h5A, 8'h00, "resume");
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
